id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32 core.
- Captures decoded instruction fields and register-file operands from ID, and presents them to EX and to the forwarding logic.
- Detects load-use hazards, inserts one bubble, and stalls IF/ID.
- Bypasses same-cycle WB writes into captured and held operands so EX never sees a stale register value.

---
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble and WB bypass (optional ID_EX_PERF_CNT_EN counters)
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [5:0]      id_instr_id,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic            id_rs1_valid,
  input  logic            id_rs2_valid,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_rd_valid,
  input  logic            id_is_load,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            wb_wr_en,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [5:0]      ex_instr_id,
  output logic [4:0]      ex_rs1_addr,
  output logic [4:0]      ex_rs2_addr,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_rs1_valid,
  output logic            ex_rs2_valid,
  output logic            ex_rd_valid,
  output logic            ex_is_load,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_flush_cnt,
`endif
  output logic            load_use_stall
);

  logic            hazard;
  logic            wb_live;
  logic [XLEN-1:0] cap_rs1_data;
  logic [XLEN-1:0] cap_rs2_data;
  logic            hold_rs1_hit;
  logic            hold_rs2_hit;

  // Load in EX whose result the ID instruction needs; x0 never creates a dependency
  always_comb begin
    hazard = ex_valid & ex_is_load & ex_rd_valid & (ex_rd_addr != 5'd0) & id_valid &
             ((id_rs1_valid & (id_rs1_addr == ex_rd_addr)) |
              (id_rs2_valid & (id_rs2_addr == ex_rd_addr)));
  end

  assign load_use_stall = hazard & ~stall_in & ~flush_in;

  // WB write that lands this cycle is not yet visible in the register-file read data
  always_comb begin
    wb_live      = wb_wr_en & (wb_rd_addr != 5'd0);
    cap_rs1_data = (wb_live && (wb_rd_addr == id_rs1_addr)) ? wb_data : id_rs1_data;
    cap_rs2_data = (wb_live && (wb_rd_addr == id_rs2_addr)) ? wb_data : id_rs2_data;
    hold_rs1_hit = wb_live & (wb_rd_addr == ex_rs1_addr) & ex_rs1_valid;
    hold_rs2_hit = wb_live & (wb_rd_addr == ex_rs2_addr) & ex_rs2_valid;
  end

  // Pipeline register: reset > flush > stall (with hold bypass) > hazard bubble > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_instr_id  <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rd_addr   <= '0;
      ex_rs1_valid <= 1'b0;
      ex_rs2_valid <= 1'b0;
      ex_rd_valid  <= 1'b0;
      ex_is_load   <= 1'b0;
    end else if (flush_in || (!stall_in && hazard)) begin
      ex_valid     <= 1'b0;
      ex_rs1_valid <= 1'b0;
      ex_rs2_valid <= 1'b0;
      ex_rd_valid  <= 1'b0;
      ex_is_load   <= 1'b0;
    end else if (stall_in) begin
      if (hold_rs1_hit) ex_rs1_data <= wb_data;
      if (hold_rs2_hit) ex_rs2_data <= wb_data;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_rs1_data  <= cap_rs1_data;
      ex_rs2_data  <= cap_rs2_data;
      ex_instr_id  <= id_instr_id;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_rd_addr   <= id_rd_addr;
      ex_rs1_valid <= id_rs1_valid & id_valid;
      ex_rs2_valid <= id_rs2_valid & id_valid;
      ex_rd_valid  <= id_rd_valid & id_valid;
      ex_is_load   <= id_is_load & id_valid;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Event counters; they follow the same priority as the pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else if (flush_in) begin
      perf_flush_cnt  <= perf_flush_cnt + 32'd1;
    end else if (!stall_in && hazard) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall_in, flush_in, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [5:0]  id_instr_id;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
  logic        id_rs1_valid, id_rs2_valid, id_rd_valid, id_is_load, wb_wr_en;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [5:0]  ex_instr_id;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic        ex_rs1_valid, ex_rs2_valid, ex_rd_valid, ex_is_load;
  logic        load_use_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr_id(id_instr_id),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_valid(id_rs1_valid), .id_rs2_valid(id_rs2_valid),
    .id_rd_addr(id_rd_addr), .id_rd_valid(id_rd_valid), .id_is_load(id_is_load),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_instr_id(ex_instr_id),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_valid(ex_rs1_valid), .ex_rs2_valid(ex_rs2_valid),
    .ex_rd_valid(ex_rd_valid), .ex_is_load(ex_is_load),
`ifdef ID_EX_PERF_CNT_EN
    .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .load_use_stall(load_use_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] iid, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic v1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic v2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic vrd, input logic ld);
    id_valid = 1'b1; id_instr_id = iid; id_pc = pc; id_imm = pc + 32'h1000;
    id_rs1_addr = rs1; id_rs1_valid = v1; id_rs1_data = d1;
    id_rs2_addr = rs2; id_rs2_valid = v2; id_rs2_data = d2;
    id_rd_addr = rd; id_rd_valid = vrd; id_is_load = ld;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    wb_wr_en = 1'b0; wb_rd_addr = '0; wb_data = '0;
    set_id(6'd10, 32'h80, 5'd1, 1'b1, 32'h1, 5'd2, 1'b1, 32'h2, 5'd3, 1'b1, 1'b1);

    // reset for two edges with a valid ID instruction present
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ex_valid", ex_valid, 1'b0);
      check("rst_flags", {ex_rs1_valid, ex_rs2_valid, ex_rd_valid, ex_is_load}, 4'b0);
      check("rst_lus", load_use_stall, 1'b0);
    end
`ifdef ID_EX_PERF_CNT_EN
    check("rst_perf_bubble", perf_bubble_cnt, 32'd0);
    check("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
    rst = 1'b0;

    // lw x5, 0(x2)
    set_id(6'd3, 32'h100, 5'd2, 1'b1, 32'h100, 5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 1'b1);
    tick();
    check("lw_ex_valid", ex_valid, 1'b1);
    check("lw_ex_is_load", ex_is_load, 1'b1);
    check("lw_ex_rd", ex_rd_addr, 5'd5);
    check("lw_ex_pc", ex_pc, 32'h100);
    check("lw_ex_imm", ex_imm, 32'h1100);

    // add x6, x5, x7 -> load-use hazard
    set_id(6'd10, 32'h104, 5'd5, 1'b1, 32'h0, 5'd7, 1'b1, 32'h77, 5'd6, 1'b1, 1'b0);
    #1;
    check("lu_stall_on", load_use_stall, 1'b1);
    tick();
    check("lu_bubble_valid", ex_valid, 1'b0);
    check("lu_bubble_load", ex_is_load, 1'b0);
    check("lu_stall_off", load_use_stall, 1'b0);
    tick();
    check("lu_add_valid", ex_valid, 1'b1);
    check("lu_add_iid", ex_instr_id, 6'd10);
    check("lu_add_rs1", ex_rs1_addr, 5'd5);
    check("lu_add_rs2_data", ex_rs2_data, 32'h77);
`ifdef ID_EX_PERF_CNT_EN
    check("lu_perf_bubble", perf_bubble_cnt, 32'd1);
`endif

    // lw x0 followed by a reader of x0: no hazard
    set_id(6'd3, 32'h108, 5'd1, 1'b1, 32'h10, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b1);
    tick();
    check("x0_lw_load", ex_is_load, 1'b1);
    set_id(6'd11, 32'h10c, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 5'd6, 1'b1, 1'b0);
    #1;
    check("x0_lus", load_use_stall, 1'b0);
    tick();
    check("x0_no_bubble", ex_valid, 1'b1);
    check("x0_iid", ex_instr_id, 6'd11);

    // capture bypass on rs1, x0 never bypassed on rs2
    set_id(6'd12, 32'h110, 5'd3, 1'b1, 32'h11, 5'd0, 1'b1, 32'h0, 5'd4, 1'b1, 1'b0);
    wb_wr_en = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'hAB;
    tick();
    check("cap_byp_rs1", ex_rs1_data, 32'hAB);
    check("cap_byp_rs2_x0", ex_rs2_data, 32'h0);
    wb_rd_addr = 5'd0; wb_data = 32'hDEAD;
    set_id(6'd12, 32'h114, 5'd0, 1'b1, 32'h0, 5'd4, 1'b1, 32'h44, 5'd4, 1'b1, 1'b0);
    tick();
    check("cap_x0_rs1", ex_rs1_data, 32'h0);
    check("cap_nohit_rs2", ex_rs2_data, 32'h44);
    wb_wr_en = 1'b0;

    // hold bypass during a three-cycle stall
    set_id(6'd13, 32'h200, 5'd8, 1'b1, 32'h88, 5'd9, 1'b1, 32'h99, 5'd10, 1'b1, 1'b0);
    tick();
    check("hold_pre_rs2", ex_rs2_data, 32'h99);
    stall_in = 1'b1;
    set_id(6'd14, 32'h300, 5'd1, 1'b1, 32'h1, 5'd2, 1'b1, 32'h2, 5'd11, 1'b1, 1'b0);
    tick();
    check("hold1_pc", ex_pc, 32'h200);
    check("hold1_rs2", ex_rs2_data, 32'h99);
    wb_wr_en = 1'b1; wb_rd_addr = 5'd9; wb_data = 32'h55;
    tick();
    check("hold2_rs2_byp", ex_rs2_data, 32'h55);
    check("hold2_rs1", ex_rs1_data, 32'h88);
    check("hold2_pc", ex_pc, 32'h200);
    check("hold2_iid", ex_instr_id, 6'd13);
    check("hold2_rd", ex_rd_addr, 5'd10);
    wb_wr_en = 1'b0;
    tick();
    check("hold3_rs2", ex_rs2_data, 32'h55);
    check("hold3_valid", ex_valid, 1'b1);
    stall_in = 1'b0;
    tick();
    check("release_iid", ex_instr_id, 6'd14);
    check("release_pc", ex_pc, 32'h300);

    // stall wins over hazard, then flush wins over hazard
    set_id(6'd3, 32'h400, 5'd2, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(6'd10, 32'h404, 5'd1, 1'b1, 32'h0, 5'd5, 1'b1, 32'h0, 5'd6, 1'b1, 1'b0);
    stall_in = 1'b1;
    #1;
    check("stallhz_lus", load_use_stall, 1'b0);
    tick();
    check("stallhz_held_load", ex_is_load, 1'b1);
    stall_in = 1'b0;
    #1;
    check("stallhz_reeval", load_use_stall, 1'b1);
    flush_in = 1'b1;
    #1;
    check("flushhz_lus", load_use_stall, 1'b0);
    tick();
    check("flush_valid", ex_valid, 1'b0);
    check("flush_flags", {ex_rs1_valid, ex_rs2_valid, ex_rd_valid, ex_is_load}, 4'b0);
`ifdef ID_EX_PERF_CNT_EN
    check("flush_perf_flush", perf_flush_cnt, 32'd1);
    check("flush_perf_bubble", perf_bubble_cnt, 32'd1);
`endif
    flush_in = 1'b0;
    tick();
    check("post_flush_valid", ex_valid, 1'b1);
    check("post_flush_iid", ex_instr_id, 6'd10);

    // invalid ID instruction clears every flag
    id_valid = 1'b0;
    tick();
    check("idle_valid", ex_valid, 1'b0);
    check("idle_flags", {ex_rs1_valid, ex_rs2_valid, ex_rd_valid, ex_is_load}, 4'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
